// File: rtl/l1a_sample_capture_if.sv
// Trigger/control bundle between the L1A
// source, the capture framer and the sample buffer.
interface l1a_sample_capture_if #(
  parameter int NSAMP_W = 5,
  parameter int EVT_W   = 12
);
  logic               L1A;
  logic               L1A_MATCH;
  logic               L1A_CNT_RST;
  logic [NSAMP_W-1:0] NSAMP;
  logic               PIPE_RUN;
  logic               BUF_AFULL;
  logic               HDR_WE;
  logic [EVT_W-1:0]   EVT_NUM;
  logic               SAMP_WE;
  logic [NSAMP_W-1:0] SAMP_IDX;
  logic               FIRST;
  logic               LAST;
  logic               EVT_DONE;
  logic               BUSY;
  logic               DROP;
  logic [7:0]         DROP_CNT;

  modport master (
    output L1A,
    output L1A_MATCH,
    output L1A_CNT_RST,
    output NSAMP,
    output PIPE_RUN,
    output BUF_AFULL,
    input  HDR_WE,
    input  EVT_NUM,
    input  SAMP_WE,
    input  SAMP_IDX,
    input  FIRST,
    input  LAST,
    input  EVT_DONE,
    input  BUSY,
    input  DROP,
    input  DROP_CNT
  );

  modport slave (
    input  L1A,
    input  L1A_MATCH,
    input  L1A_CNT_RST,
    input  NSAMP,
    input  PIPE_RUN,
    input  BUF_AFULL,
    output HDR_WE,
    output EVT_NUM,
    output SAMP_WE,
    output SAMP_IDX,
    output FIRST,
    output LAST,
    output EVT_DONE,
    output BUSY,
    output DROP,
    output DROP_CNT
  );
endinterface

// File: rtl/l1a_sample_capture.sv
// Frames NSAMP pipeline words per accepted L1A
// as header, samples and end-of-event strobes.
module l1a_sample_capture #(
  parameter int NSAMP_W  = 5,
  parameter int MAX_SAMP = 16,
  parameter int EVT_W    = 12
) (
  input logic CLK,
  input logic RST,
  l1a_sample_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    SAMP,
    DONE
  } state_t;

  localparam logic [NSAMP_W-1:0] MAX_S =
    NSAMP_W'(MAX_SAMP);
  localparam logic [NSAMP_W-1:0] ONE_S =
    NSAMP_W'(1);

  state_t             state_q;
  state_t             state_d;
  logic [EVT_W-1:0]   cnt_q;
  logic [EVT_W-1:0]   cnt_d;
  logic [NSAMP_W-1:0] nlat_q;
  logic [NSAMP_W-1:0] nsamp_c;
  logic [NSAMP_W-1:0] idx_d;
  logic [NSAMP_W-1:0] last_idx;
  logic [7:0]         dcnt_d;
  logic               accept;
  logic               reject;
  logic               samp_d;
  logic               last_d;

  always_comb begin
    nsamp_c = bus.NSAMP;
    if (bus.NSAMP == '0)
      nsamp_c = ONE_S;
    else if (bus.NSAMP > MAX_S)
      nsamp_c = MAX_S;
  end

  // Pipeline data cannot stall, so gating
  // only applies at the accept decision.
  assign accept = bus.L1A
                & bus.L1A_MATCH
                & (state_q == IDLE)
                & bus.PIPE_RUN
                & ~bus.BUF_AFULL;

  assign reject = bus.L1A
                & bus.L1A_MATCH
                & ~accept;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.L1A_CNT_RST)
      cnt_d = EVT_W'(bus.L1A);
    else if (bus.L1A)
      cnt_d = cnt_q + EVT_W'(1);
  end

  always_comb begin
    dcnt_d = bus.DROP_CNT;
    if (bus.L1A_CNT_RST)
      dcnt_d = {7'd0, reject};
    else if (reject && bus.DROP_CNT != 8'hFF)
      dcnt_d = bus.DROP_CNT + 8'd1;
  end

  assign last_idx = nlat_q - ONE_S;

  always_comb begin
    state_d = state_q;
    idx_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = HDR;
      end
      HDR: begin
        state_d = SAMP;
      end
      SAMP: begin
        if (bus.SAMP_IDX == last_idx)
          state_d = DONE;
        else
          idx_d = bus.SAMP_IDX + ONE_S;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign samp_d = (state_d == SAMP);
  assign last_d = samp_d
                & (idx_d == last_idx);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nlat_q       <= '0;
      bus.HDR_WE   <= 1'b0;
      bus.EVT_NUM  <= '0;
      bus.SAMP_WE  <= 1'b0;
      bus.SAMP_IDX <= '0;
      bus.FIRST    <= 1'b0;
      bus.LAST     <= 1'b0;
      bus.EVT_DONE <= 1'b0;
      bus.BUSY     <= 1'b0;
      bus.DROP     <= 1'b0;
      bus.DROP_CNT <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus.HDR_WE   <= (state_d == HDR);
      bus.SAMP_WE  <= samp_d;
      bus.SAMP_IDX <= samp_d ? idx_d : '0;
      bus.FIRST    <= samp_d & (idx_d == '0);
      bus.LAST     <= last_d;
      bus.EVT_DONE <= (state_d == DONE);
      bus.BUSY     <= (state_d != IDLE);
      bus.DROP     <= reject;
      bus.DROP_CNT <= dcnt_d;
      if (accept) begin
        bus.EVT_NUM <= cnt_d;
        nlat_q      <= nsamp_c;
      end
    end
  end

endmodule

// File: tb/tb_l1a_sample_capture.sv
// Random and directed check of the L1A
// capture framer against a timing model.
module tb_l1a_sample_capture;

  logic CLK;
  logic RST;

  l1a_sample_capture_if #(
    .NSAMP_W(5),
    .EVT_W(12)
  ) bus ();

  l1a_sample_capture #(
    .NSAMP_W(5),
    .MAX_SAMP(16),
    .EVT_W(12)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int ta = -1000;
  int n = 1;
  int m_cnt = 0;
  int m_tag = 0;
  int m_drop = 0;
  bit m_dp = 0;

  task automatic chk(
    input string tag,
    input int obs,
    input int exp
  );
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               tag, cyc, obs, exp);
    end
  endtask

  function automatic int clamp(input int ns);
    if (ns == 0) return 1;
    if (ns > 16) return 16;
    return ns;
  endfunction

  task automatic model_reset();
    ta = -1000;
    n = 1;
    m_cnt = 0;
    m_tag = 0;
    m_drop = 0;
    m_dp = 0;
  endtask

  // Expected outputs come straight from the
  // event timeline t+1 .. t+2+N of the last accept.
  task automatic check_outs();
    int rel;
    int idx;
    bit samp;
    rel  = cyc - ta;
    samp = (rel >= 2) && (rel <= 1 + n);
    idx  = samp ? rel - 2 : 0;
    chk("hdr_we", int'(bus.HDR_WE), int'(rel == 1));
    chk("samp_we", int'(bus.SAMP_WE), int'(samp));
    chk("samp_idx", int'(bus.SAMP_IDX), idx);
    chk("first", int'(bus.FIRST),
        int'(samp && idx == 0));
    chk("last", int'(bus.LAST),
        int'(samp && idx == n - 1));
    chk("evt_done", int'(bus.EVT_DONE),
        int'(rel == 2 + n));
    chk("busy", int'(bus.BUSY),
        int'(rel >= 1 && rel <= 2 + n));
    chk("evt_num", int'(bus.EVT_NUM), m_tag);
    chk("drop", int'(bus.DROP), int'(m_dp));
    chk("drop_cnt", int'(bus.DROP_CNT), m_drop);
  endtask

  task automatic step(
    input bit l1a,
    input bit match,
    input bit crst,
    input int ns,
    input bit prun,
    input bit afull
  );
    bit idle;
    bit acc;
    bit rej;
    bus.L1A         = l1a;
    bus.L1A_MATCH   = match;
    bus.L1A_CNT_RST = crst;
    bus.NSAMP       = 5'(ns);
    bus.PIPE_RUN    = prun;
    bus.BUF_AFULL   = afull;
    if (!RST) begin
      idle = (cyc >= ta + 3 + n);
      acc  = l1a && match && idle && prun && !afull;
      rej  = l1a && match && !acc;
      if (crst)
        m_cnt = l1a ? 1 : 0;
      else if (l1a)
        m_cnt = (m_cnt + 1) % 4096;
      if (acc) begin
        ta = cyc;
        n = clamp(ns);
        m_tag = m_cnt;
      end
      if (crst)
        m_drop = rej ? 1 : 0;
      else if (rej && m_drop < 255)
        m_drop++;
      m_dp = rej;
    end
    @(posedge CLK);
    cyc++;
    #1;
    check_outs();
  endtask

  task automatic idle_n(input int k);
    for (int i = 0; i < k; i++)
      step(0, 0, 0, 8, 1, 0);
  endtask

  task automatic run_count(
    input int k,
    input int ns,
    output int we
  );
    we = 0;
    for (int i = 0; i < k; i++) begin
      step(0, 0, 0, ns, 1, 0);
      we += int'(bus.SAMP_WE);
    end
  endtask

  int we;

  initial begin
    RST = 1'b1;
    bus.L1A         = 1'b0;
    bus.L1A_MATCH   = 1'b0;
    bus.L1A_CNT_RST = 1'b0;
    bus.NSAMP       = 5'd8;
    bus.PIPE_RUN    = 1'b1;
    bus.BUF_AFULL   = 1'b0;
    @(posedge CLK);
    cyc++;
    #1;
    check_outs();
    step(0, 0, 0, 8, 1, 0);
    RST = 1'b0;

    // single event
    idle_n(9);
    step(1, 1, 0, 8, 1, 0);
    chk("single_hdr", int'(bus.HDR_WE), 1);
    chk("single_evt", int'(bus.EVT_NUM), 1);
    run_count(11, 8, we);
    chk("single_nsamp", we, 8);

    // overlap
    step(0, 0, 1, 8, 1, 0);
    step(1, 1, 0, 8, 1, 0);
    idle_n(4);
    step(1, 1, 0, 8, 1, 0);
    chk("ovl_drop", int'(bus.DROP), 1);
    chk("ovl_dcnt", int'(bus.DROP_CNT), 1);
    chk("ovl_evt", int'(bus.EVT_NUM), 1);
    idle_n(5);
    step(1, 1, 0, 8, 1, 0);
    chk("ovl_evt3", int'(bus.EVT_NUM), 3);
    idle_n(12);

    // gating
    step(0, 0, 1, 8, 1, 0);
    step(1, 1, 0, 8, 1, 1);
    step(1, 1, 0, 8, 0, 0);
    step(1, 0, 0, 8, 1, 0);
    chk("gate_dcnt", int'(bus.DROP_CNT), 2);
    step(1, 1, 0, 8, 1, 0);
    chk("gate_evt", int'(bus.EVT_NUM), 4);
    idle_n(12);

    // clamping
    step(1, 1, 0, 0, 1, 0);
    run_count(5, 0, we);
    chk("clamp_zero", we, 1);
    step(1, 1, 0, 31, 1, 0);
    run_count(20, 31, we);
    chk("clamp_max", we, 16);
    step(1, 1, 0, 8, 1, 0);
    run_count(12, 4, we);
    chk("clamp_latch", we, 8);

    // counter wrap
    step(0, 0, 1, 8, 1, 0);
    for (int i = 0; i < 4095; i++)
      step(1, 0, 0, 8, 1, 0);
    step(1, 1, 0, 8, 1, 0);
    chk("wrap_evt", int'(bus.EVT_NUM), 0);
    idle_n(12);

    // drop saturation
    for (int i = 0; i < 300; i++)
      step(1, 1, 0, 8, 1, 1);
    chk("sat_dcnt", int'(bus.DROP_CNT), 255);

    // clear together with L1A
    step(1, 0, 1, 8, 1, 0);
    step(1, 1, 0, 8, 1, 0);
    chk("crst_l1a_evt", int'(bus.EVT_NUM), 2);
    idle_n(12);

    // reset mid-capture at SAMP_IDX=3
    step(1, 1, 0, 8, 1, 0);
    idle_n(4);
    chk("pre_rst_idx", int'(bus.SAMP_IDX), 3);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_outs();
    step(0, 0, 0, 8, 1, 0);
    step(0, 0, 0, 8, 1, 0);
    RST = 1'b0;
    idle_n(2);
    step(1, 1, 0, 8, 1, 0);
    chk("post_rst_evt", int'(bus.EVT_NUM), 1);
    idle_n(12);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3) == 0,
           $urandom_range(3) != 0,
           $urandom_range(31) == 0,
           int'($urandom_range(31)),
           $urandom_range(7) != 0,
           $urandom_range(7) == 0);
    end
    idle_n(20);

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/l1a_sample_capture.md
Name: l1a_sample_capture

Overview:
- Sits directly downstream of the per-group pipeline FIFOs, in the read-clock domain.
- On a matched L1A it frames a window of NSAMP consecutive pipeline output words (GxPIPOUT) as one event for the sample buffer.
- Emits a header strobe carrying the event number, then one write strobe per sample, then an end-of-event pulse.
- Rejected triggers are counted so event tags stay aligned with the global L1A count.

Parameters:
- NSAMP_W, 5: width of the NSAMP input.
- MAX_SAMP, 16: largest allowed window length; larger requests are clamped to this.
- EVT_W, 12: width of the event (L1A) counter and tag.

Ports:
- CLK  in  1  read clock; same as the pipeline RDCLK.
- RST  in  1  asynchronous, active-high reset.
- L1A  in  1  level-1 accept pulse, one cycle.
- L1A_MATCH  in  1  L1A qualified for this board; only meaningful when L1A=1.
- L1A_CNT_RST  in  1  synchronous clear of the event counter and DROP_CNT.
- NSAMP  in  NSAMP_W  samples per event.
- PIPE_RUN  in  1  pipeline read side is running (RE active).
- BUF_AFULL  in  1  downstream sample buffer is almost full.
- HDR_WE  out  1  header write strobe.
- EVT_NUM  out  EVT_W  tag of the current or last accepted event.
- SAMP_WE  out  1  sample write strobe; capture GxPIPOUT this cycle.
- SAMP_IDX  out  NSAMP_W  index of the current sample, starting at 0.
- FIRST  out  1  marks sample 0.
- LAST  out  1  marks the final sample.
- EVT_DONE  out  1  end-of-event pulse.
- BUSY  out  1  high whenever the state is not IDLE.
- DROP  out  1  one-cycle pulse when a matched L1A is rejected.
- DROP_CNT  out  8  count of rejected matched L1As; saturates.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; event counter 0; DROP_CNT 0; latched sample count 0. Reset asserted mid-capture aborts the event at once; no EVT_DONE is produced.
- Event counter:
  - Increments on every cycle with L1A=1, whether matched or not; wraps 4095 to 0.
  - L1A_CNT_RST alone sets it to 0. L1A_CNT_RST together with L1A sets it to 1.
  - L1A_CNT_RST also clears DROP_CNT; a simultaneous DROP leaves DROP_CNT at 1.
- Acceptance:
  - Condition, checked in cycle t: L1A & L1A_MATCH & state==IDLE & PIPE_RUN & ~BUF_AFULL.
  - On acceptance, register EVT_NUM = new counter value.
  - Latch NSAMP: 0 becomes 1; values above MAX_SAMP become MAX_SAMP. Later changes to NSAMP do not affect the event in flight.
- Rejection:
  - Condition: L1A & L1A_MATCH with any acceptance term false.
  - Action: DROP=1 at t+1; DROP_CNT increments, saturating at 255. EVT_NUM is unchanged.
- State machine: IDLE, HDR, SAMP, DONE.
  - IDLE to HDR on acceptance. HDR_WE=1 at t+1.
  - HDR to SAMP unconditionally. SAMP_WE=1 for cycles t+2 .. t+1+N, where N is the latched count. SAMP_IDX counts 0..N-1.
  - FIRST is asserted when SAMP_IDX=0. LAST is asserted when SAMP_IDX=N-1. With N=1, both are asserted in the same cycle.
  - SAMP to DONE after the LAST cycle. EVT_DONE=1 at t+2+N.
  - DONE to IDLE unconditionally. BUSY=0 from t+3+N.
  - A new L1A is accepted no earlier than cycle t+3+N; minimum trigger spacing is N+3 cycles.
- Buffer and pipe conditions during capture: BUF_AFULL and PIPE_RUN are ignored once an event is accepted. The event always completes, because pipeline data cannot be stalled.
- Outputs: all outputs are registered. SAMP_IDX, FIRST and LAST are 0 whenever SAMP_WE=0.

Test Plan:
- Single event: NSAMP=8, PIPE_RUN=1, one matched L1A at cycle 10 -> HDR_WE at 11 with EVT_NUM=1; SAMP_WE at 12..19 with SAMP_IDX 0..7, FIRST at 12, LAST at 19; EVT_DONE at 20; BUSY low from 21.
- Overlap: NSAMP=8; matched L1A at 10 and again at 15 -> second L1A gives DROP at 16, DROP_CNT=1, counter=2, EVT_NUM stays 1. A further matched L1A at 21 is accepted with EVT_NUM=3.
- Gating: matched L1A with BUF_AFULL=1, then with PIPE_RUN=0, then an unmatched L1A -> two DROP pulses, DROP_CNT=2, counter=3, no HDR_WE.
- Clamping: NSAMP=0 -> one SAMP_WE cycle with FIRST=LAST=1. NSAMP=31 -> 16 samples. NSAMP changed 8 to 4 mid-capture -> 8 samples.
- Wrap and saturation: counter preloaded to 4095 via 4095 L1As, next accepted event -> EVT_NUM=0. 300 rejected L1As -> DROP_CNT=255. L1A_CNT_RST with L1A -> counter=1.
- Reset mid-capture: RST at SAMP_IDX=3 -> all outputs 0 immediately, no EVT_DONE. After release, next L1A -> EVT_NUM=1.
